// File: rtl/can_mac_pkg.sv
// rtl/can_mac_pkg.sv - shared types and constants for the CAN receive MAC
package can_mac_pkg;

  typedef enum logic [3:0] {
    ST_INTEG,
    ST_IDLE,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DELIM,
    ST_ACK,
    ST_ACK_DELIM,
    ST_EOF,
    ST_INTERMISSION,
    ST_ERROR
  } rx_state_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_STUFF       = 3'd1,
    ERR_FORM        = 3'd2,
    ERR_CRC         = 3'd3,
    ERR_UNSUPPORTED = 3'd4
  } err_code_t;

  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam int CRC_W             = 15;
  localparam int ID_W              = 11;
  localparam int DLC_W             = 4;
  localparam int DATA_W            = 64;
  localparam int ARB_BITS          = 12;
  localparam int CTRL_BITS         = 6;
  localparam int STUFF_RUN         = 5;
  localparam int EOF_BITS          = 7;
  localparam int INTERMISSION_BITS = 3;
  localparam int IDLE_RUN          = 11;

endpackage

// File: rtl/CRC_Unit.sv
// rtl/CRC_Unit.sv - serial MSB-first CRC register with synchronous clear
module CRC_Unit #(
  parameter int              WIDTH = 15,
  parameter logic [WIDTH-1:0] POLY = 15'h4599
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] crc
);

  logic fb;

  assign fb = din ^ crc[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (shift) begin
      crc <= {crc[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb}} & POLY);
    end
  end

endmodule

// File: rtl/can_mac_rx_destuffer.sv
// rtl/can_mac_rx_destuffer.sv - removes CAN stuff bits and flags stuff violations
module can_mac_rx_destuffer
  import can_mac_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  input  logic active,
  input  logic bit_in,
  output logic bit_out,
  output logic valid,
  output logic stuff_err
);

  logic       last_level;
  logic [2:0] run_cnt;
  logic       stuff_slot;

  assign stuff_slot = (run_cnt == 3'(STUFF_RUN));
  assign bit_out    = bit_in;
  assign valid      = en && active && !stuff_slot;
  assign stuff_err  = en && active && stuff_slot && (bit_in == last_level);

  // SOF itself is dominant and opens the first run; a stuff bit starts a new run
  always_ff @(posedge clk) begin
    if (rst) begin
      last_level <= 1'b1;
      run_cnt    <= '0;
    end else if (en) begin
      if (restart) begin
        last_level <= 1'b0;
        run_cnt    <= 3'd1;
      end else if (active) begin
        if (stuff_slot || (bit_in != last_level)) begin
          last_level <= bit_in;
          run_cnt    <= 3'd1;
        end else begin
          run_cnt <= run_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/can_mac_rx.sv
// rtl/can_mac_rx.sv - CAN 2.0A receive MAC; ACK driving enabled by CAN_RX_ACK_EN
module can_mac_rx
  import can_mac_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        can_clk_en,
  input  logic        can_rx,
  output logic        ack_drive,
  output logic        ind_valid,
  output logic [10:0] ind_identifier,
  output logic        ind_rtr,
  output logic [3:0]  ind_dlc,
  output logic [63:0] ind_data,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic        rx_busy
);

`ifdef CAN_RX_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  if (CLK_FREQ_HZ <= 0) begin : g_freq_check
    $error("CLK_FREQ_HZ must be positive");
  end

  rx_state_t         state;
  logic [6:0]        bit_cnt;
  logic [6:0]        data_bits;
  logic [ID_W-1:0]   id_sr;
  logic              rtr_r;
  logic [DLC_W-1:0]  dlc_sr;
  logic [DLC_W-1:0]  dlc_next;
  logic [DATA_W-1:0] data_sr;
  logic [CRC_W-2:0]  crc_rx;
  logic              crc_ok;
  logic [CRC_W-1:0]  crc_calc;
  logic              ds_bit, ds_valid, ds_err, ds_active;
  logic              sof, crc_shift;
  logic              err_now;
  err_code_t         err_sel;

  assign ds_active = state inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
  assign sof       = can_clk_en && !can_rx && (state inside {ST_IDLE, ST_INTERMISSION});
  assign crc_shift = ds_valid && (state inside {ST_ARB, ST_CTRL, ST_DATA});
  assign dlc_next  = {dlc_sr[DLC_W-2:0], ds_bit};
  assign rx_busy   = !(state inside {ST_IDLE, ST_INTEG});

  can_mac_rx_destuffer u_destuffer (
    .clk      (clk),
    .rst      (rst),
    .en       (can_clk_en),
    .restart  (sof),
    .active   (ds_active),
    .bit_in   (can_rx),
    .bit_out  (ds_bit),
    .valid    (ds_valid),
    .stuff_err(ds_err)
  );

  CRC_Unit #(.WIDTH(CRC_W), .POLY(CRC15_POLY)) u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (sof),
    .shift(crc_shift),
    .din  (ds_bit),
    .crc  (crc_calc)
  );

  always_comb begin
    err_now = 1'b0;
    err_sel = ERR_NONE;
    if (ds_err) begin
      err_now = 1'b1;
      err_sel = ERR_STUFF;
    end else if (can_clk_en) begin
      case (state)
        ST_CTRL: if (ds_valid && bit_cnt == 7'd0 && ds_bit) begin
          err_now = 1'b1;
          err_sel = ERR_UNSUPPORTED;
        end
        ST_CRC_DELIM, ST_EOF: if (!can_rx) begin
          err_now = 1'b1;
          err_sel = ERR_FORM;
        end
        // a bad delimiter outranks the CRC verdict
        ST_ACK_DELIM: if (!can_rx || !crc_ok) begin
          err_now = 1'b1;
          err_sel = !can_rx ? ERR_FORM : ERR_CRC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INTEG;  bit_cnt <= '0;  data_bits <= '0;
      id_sr <= '0;  rtr_r <= 1'b0;  dlc_sr <= '0;  data_sr <= '0;
      crc_rx <= '0;  crc_ok <= 1'b0;  ack_drive <= 1'b0;
      ind_valid <= 1'b0;  ind_identifier <= '0;  ind_rtr <= 1'b0;
      ind_dlc <= '0;  ind_data <= '0;  err_valid <= 1'b0;  err_code <= '0;
    end else begin
      ind_valid <= 1'b0;
      err_valid <= 1'b0;
      if (err_now) begin
        state     <= ST_ERROR;
        bit_cnt   <= '0;
        err_valid <= 1'b1;
        err_code  <= err_sel;
        ack_drive <= 1'b0;
      end else if (can_clk_en) begin
        case (state)
          ST_INTEG, ST_ERROR: begin
            if (!can_rx) bit_cnt <= '0;
            else if (bit_cnt == 7'(IDLE_RUN - 1)) begin
              state   <= ST_IDLE;
              bit_cnt <= '0;
            end else bit_cnt <= bit_cnt + 7'd1;
          end
          ST_IDLE, ST_INTERMISSION: begin
            if (!can_rx) begin
              state <= ST_ARB;  bit_cnt <= '0;  data_bits <= '0;
              id_sr <= '0;  rtr_r <= 1'b0;  dlc_sr <= '0;  data_sr <= '0;
              crc_rx <= '0;  crc_ok <= 1'b0;
            end else if (state == ST_INTERMISSION) begin
              if (bit_cnt == 7'(INTERMISSION_BITS - 1)) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
              end else bit_cnt <= bit_cnt + 7'd1;
            end
          end
          ST_ARB: if (ds_valid) begin
            if (bit_cnt == 7'(ARB_BITS - 1)) begin
              rtr_r   <= ds_bit;
              state   <= ST_CTRL;
              bit_cnt <= '0;
            end else begin
              id_sr   <= {id_sr[ID_W-2:0], ds_bit};
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          ST_CTRL: if (ds_valid) begin
            if (bit_cnt == 7'(CTRL_BITS - 1)) begin
              dlc_sr    <= dlc_next;
              data_bits <= (dlc_next > 4'd8) ? 7'd64 : {dlc_next, 3'b000};
              state     <= (rtr_r || dlc_next == 4'd0) ? ST_CRC : ST_DATA;
              bit_cnt   <= '0;
            end else begin
              if (bit_cnt >= 7'd2) dlc_sr <= dlc_next;
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          ST_DATA: if (ds_valid) begin
            data_sr <= {data_sr[DATA_W-2:0], ds_bit};
            if (bit_cnt == data_bits - 7'd1) begin
              state   <= ST_CRC;
              bit_cnt <= '0;
            end else bit_cnt <= bit_cnt + 7'd1;
          end
          ST_CRC: if (ds_valid) begin
            crc_rx <= {crc_rx[CRC_W-3:0], ds_bit};
            if (bit_cnt == 7'(CRC_W - 1)) begin
              crc_ok  <= ({crc_rx, ds_bit} == crc_calc);
              state   <= ST_CRC_DELIM;
              bit_cnt <= '0;
            end else bit_cnt <= bit_cnt + 7'd1;
          end
          ST_CRC_DELIM: begin
            state     <= ST_ACK;
            ack_drive <= ACK_EN && crc_ok;
          end
          ST_ACK: begin
            state     <= ST_ACK_DELIM;
            ack_drive <= 1'b0;
          end
          ST_ACK_DELIM: begin
            state   <= ST_EOF;
            bit_cnt <= '0;
          end
          ST_EOF: begin
            if (bit_cnt == 7'(EOF_BITS - 1)) begin
              ind_valid      <= 1'b1;
              ind_identifier <= id_sr;
              ind_rtr        <= rtr_r;
              ind_dlc        <= dlc_sr;
              ind_data       <= data_sr;
              state          <= ST_INTERMISSION;
              bit_cnt        <= '0;
            end else bit_cnt <= bit_cnt + 7'd1;
          end
          default: state <= ST_INTEG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_mac_rx.sv
// tb/tb_can_mac_rx.sv - scoreboard bench for can_mac_rx; define CAN_RX_ACK_EN to match the RTL build
module tb_can_mac_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        can_clk_en = 1'b0;
  logic        can_rx = 1'b1;
  logic        ack_drive, ind_valid, ind_rtr, err_valid, rx_busy;
  logic [10:0] ind_identifier;
  logic [3:0]  ind_dlc;
  logic [63:0] ind_data;
  logic [2:0]  err_code;

  can_mac_rx dut (
    .clk(clk), .rst(rst), .can_clk_en(can_clk_en), .can_rx(can_rx),
    .ack_drive(ack_drive), .ind_valid(ind_valid), .ind_identifier(ind_identifier),
    .ind_rtr(ind_rtr), .ind_dlc(ind_dlc), .ind_data(ind_data),
    .err_valid(err_valid), .err_code(err_code), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

`ifdef CAN_RX_ACK_EN
  localparam int ACK_EXP = 1;
`else
  localparam int ACK_EXP = 0;
`endif

  typedef struct {
    bit          is_err;
    logic [2:0]  code;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          ack;
  } exp_t;

  exp_t sb[$];
  exp_t last_good;
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ack_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ind(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                          input logic [63:0] data);
    exp_t e;
    e.is_err = 1'b0; e.code = 3'd0; e.id = id; e.rtr = rtr; e.dlc = dlc;
    e.data = data; e.ack = ACK_EXP;
    sb.push_back(e);
    last_good = e;
  endtask

  task automatic push_err(input logic [2:0] code);
    exp_t e;
    e = last_good;
    e.is_err = 1'b1; e.code = code; e.ack = 0;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    can_rx = b;
    can_clk_en = 1'b1;
    @(posedge clk); #1;
    can_clk_en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // Builds SOF..EOF with stuffing; force_stuff sends the first stuff bit at the wrong level and stops.
  task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                            input logic [63:0] data, input logic [14:0] crc_flip,
                            input bit force_stuff, input int abort_at);
    logic raw[$];
    logic tx[$];
    logic [14:0] crc;
    logic nxt, last, sb_bit;
    int run, nb;
    bit stop;
    raw = {};
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    if (!rtr && dlc != 4'd0) begin
      nb = (dlc > 4'd8) ? 64 : int'(dlc) * 8;
      for (int i = nb - 1; i >= 0; i--) raw.push_back(data[i]);
    end
    crc = 15'h0;
    foreach (raw[i]) begin
      nxt = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nxt) crc = crc ^ 15'h4599;
    end
    crc = crc ^ crc_flip;
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    tx = {1'b0};
    last = 1'b0;
    run = 1;
    stop = 0;
    foreach (raw[i]) begin
      if (run == 5) begin
        sb_bit = force_stuff ? last : ~last;
        tx.push_back(sb_bit);
        if (force_stuff) begin
          stop = 1;
          break;
        end
        last = sb_bit;
        run = 1;
      end
      tx.push_back(raw[i]);
      if (raw[i] == last) run++;
      else begin
        last = raw[i];
        run = 1;
      end
    end
    if (!stop) begin
      tx.push_back(1'b1);
      tx.push_back(1'b0);
      for (int i = 0; i < 8; i++) tx.push_back(1'b1);
    end
    foreach (tx[k]) begin
      if (abort_at >= 0 && k == abort_at) return;
      send_bit(tx[k]);
    end
  endtask

  always @(negedge clk) begin
    if (can_clk_en && ack_drive) ack_cnt++;
    if (ind_valid || err_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: ind_valid=%0b err_valid=%0b err_code=%0d id=0x%0h, none required",
                 ind_valid, err_valid, err_code, ind_identifier);
      end else begin
        mon_e = sb.pop_front();
        check("event_err_valid", err_valid, mon_e.is_err);
        check("event_ind_valid", ind_valid, !mon_e.is_err);
        if (mon_e.is_err) check("err_code", err_code, mon_e.code);
        check("ind_identifier", ind_identifier, mon_e.id);
        check("ind_rtr", ind_rtr, mon_e.rtr);
        check("ind_dlc", ind_dlc, mon_e.dlc);
        check("ind_data", ind_data, mon_e.data);
        check("ack_drive_bits", ack_cnt, mon_e.ack);
      end
      ack_cnt = 0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ack_drive"}, ack_drive, 0);
    check({tag, "_ind_valid"}, ind_valid, 0);
    check({tag, "_ind_identifier"}, ind_identifier, 0);
    check({tag, "_ind_rtr"}, ind_rtr, 0);
    check({tag, "_ind_dlc"}, ind_dlc, 0);
    check({tag, "_ind_data"}, ind_data, 0);
    check({tag, "_err_valid"}, err_valid, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_rx_busy"}, rx_busy, 0);
  endtask

  initial begin
    last_good.is_err = 1'b0; last_good.code = 3'd0; last_good.id = 11'h0;
    last_good.rtr = 1'b0; last_good.dlc = 4'h0; last_good.data = 64'h0; last_good.ack = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    idle(11);
    push_ind(11'h123, 1'b0, 4'd2, 64'h000000000000ABCD);
    send_frame(11'h123, 1'b0, 4'd2, 64'hABCD, 15'h0, 0, -1);

    idle(11);
    push_err(3'd1);
    send_frame(11'h000, 1'b0, 4'd1, 64'h0, 15'h0, 1, -1);
    idle(12);
    push_ind(11'h456, 1'b0, 4'd1, 64'h5A);
    send_frame(11'h456, 1'b0, 4'd1, 64'h5A, 15'h0, 0, -1);

    idle(3);
    push_err(3'd3);
    send_frame(11'h7FF, 1'b0, 4'd8, 64'h0123456789ABCDEF, 15'h0001, 0, -1);

    idle(11);
    push_ind(11'h2AA, 1'b1, 4'd4, 64'h0);
    send_frame(11'h2AA, 1'b1, 4'd4, 64'h0, 15'h0, 0, -1);

    idle(3);
    push_ind(11'h100, 1'b0, 4'd3, 64'h112233);
    send_frame(11'h100, 1'b0, 4'd3, 64'h112233, 15'h0, 0, -1);
    idle(3);
    push_ind(11'h7F0, 1'b0, 4'd1, 64'hFF);
    send_frame(11'h7F0, 1'b0, 4'd1, 64'hFF, 15'h0, 0, -1);

    idle(3);
    send_frame(11'h321, 1'b0, 4'd8, 64'hFEDCBA9876543210, 15'h0, 0, 30);
    check("busy_mid_data", rx_busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_all_zero("midframe_rst");
    last_good.id = 11'h0; last_good.rtr = 1'b0; last_good.dlc = 4'h0; last_good.data = 64'h0;

    idle(4);
    send_frame(11'h055, 1'b0, 4'd1, 64'h33, 15'h0, 0, -1);
    idle(11);
    push_ind(11'h3C3, 1'b0, 4'd2, 64'h8001);
    send_frame(11'h3C3, 1'b0, 4'd2, 64'h8001, 15'h0, 0, -1);

    idle(20);
    check("pending_events", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
